axi_xbar_1to2: RTL

- Single-master, two-slave AXI4 interconnect between the core's data-side AXI master and the device slaves.
- Routes every transaction by address to either the CLINT slave (s1) or the default SoC/memory slave (s0).
- Registers and holds request fields, so slaves that sample address after the handshake see stable values.
- Read and write paths are independent; each path allows one outstanding transaction.

---
 rtl/axi_xbar_1to2_if.sv | 66 ++++++
 rtl/axi_xbar_1to2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_xbar_1to2_if.sv
// AXI4 bundle (AR/R/AW/W/B, 32-bit address, 64-bit data, 4-bit id) used by
// both the core-facing and device-facing ports of axi_xbar_1to2.
interface axi_xbar_1to2_if;
  // read address
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  // read data
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic [3:0]  rid;
  logic        rready;
  // write address
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  // write data
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wlast;
  logic        wready;
  // write response
  logic [1:0]  bresp;
  logic        bvalid;
  logic [3:0]  bid;
  logic        bready;

  // Seen from the side that issues requests.
  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst,
    input  arready,
    input  rdata, rresp, rvalid, rlast, rid,
    output rready,
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bvalid, bid,
    output bready
  );

  // Seen from the side that serves requests.
  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst,
    output arready,
    output rdata, rresp, rvalid, rlast, rid,
    input  rready,
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bvalid, bid,
    input  bready
  );
endinterface

// File: rtl/axi_xbar_1to2.sv
// One-master, two-slave AXI4 crossbar: CLINT window goes to s1, everything else to s0.
// Requests are registered and held stable; read and write paths each keep one transaction in flight.
module axi_xbar_1to2 #(
  parameter logic [31:0] CLINT_BASE  = 32'ha000_0048,
  parameter logic [31:0] CLINT_LIMIT = 32'ha000_004f
) (
  input  logic            clk,
  input  logic            rst,
  axi_xbar_1to2_if.slave  m_axi,
  axi_xbar_1to2_if.master s0_axi,
  axi_xbar_1to2_if.master s1_axi
);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_t;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

  function automatic logic is_clint(input logic [31:0] addr);
    return (addr >= CLINT_BASE) && (addr <= CLINT_LIMIT);
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e r_state_q, r_state_d;
  ax_t      ar_q, ar_d;
  logic     rsel_q, rsel_d;
  logic     ar_accept, ar_fwd, r_pass;

  logic     arready_sel, rvalid_sel, rlast_sel;

  assign arready_sel = rsel_q ? s1_axi.arready : s0_axi.arready;
  assign rvalid_sel  = rsel_q ? s1_axi.rvalid  : s0_axi.rvalid;
  assign rlast_sel   = rsel_q ? s1_axi.rlast   : s0_axi.rlast;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses <= so every register samples the pre-edge values.
    if (rst) begin
      r_state_q <= R_IDLE;
      // NOTE: the held request is reset too, so slaves never see X address/id fields.
      ar_q      <= '0;
      rsel_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      rsel_q    <= rsel_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    r_state_d = r_state_q;
    ar_d      = ar_q;
    rsel_d    = rsel_q;
    ar_accept = 1'b0;
    ar_fwd    = 1'b0;
    r_pass    = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        ar_accept = 1'b1;
        if (m_axi.arvalid) begin
          ar_d.addr  = m_axi.araddr;
          ar_d.id    = m_axi.arid;
          ar_d.len   = m_axi.arlen;
          ar_d.size  = m_axi.arsize;
          ar_d.burst = m_axi.arburst;
          rsel_d     = is_clint(m_axi.araddr);
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        ar_fwd = 1'b1;
        if (arready_sel) r_state_d = R_DATA;
      end
      R_DATA: begin
        // Burst length is not counted; the slave's rlast ends the transaction.
        r_pass = 1'b1;
        if (rvalid_sel && m_axi.rready && rlast_sel) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign m_axi.arready  = ar_accept;

  assign s0_axi.arvalid = ar_fwd && !rsel_q;
  assign s1_axi.arvalid = ar_fwd &&  rsel_q;
  assign s0_axi.araddr  = ar_q.addr;
  assign s1_axi.araddr  = ar_q.addr;
  assign s0_axi.arid    = ar_q.id;
  assign s1_axi.arid    = ar_q.id;
  assign s0_axi.arlen   = ar_q.len;
  assign s1_axi.arlen   = ar_q.len;
  assign s0_axi.arsize  = ar_q.size;
  assign s1_axi.arsize  = ar_q.size;
  assign s0_axi.arburst = ar_q.burst;
  assign s1_axi.arburst = ar_q.burst;

  assign m_axi.rvalid   = r_pass && rvalid_sel;
  assign m_axi.rdata    = rsel_q ? s1_axi.rdata : s0_axi.rdata;
  assign m_axi.rresp    = rsel_q ? s1_axi.rresp : s0_axi.rresp;
  assign m_axi.rlast    = rsel_q ? s1_axi.rlast : s0_axi.rlast;
  assign m_axi.rid      = rsel_q ? s1_axi.rid   : s0_axi.rid;
  assign s0_axi.rready  = r_pass && !rsel_q && m_axi.rready;
  assign s1_axi.rready  = r_pass &&  rsel_q && m_axi.rready;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e w_state_q, w_state_d;
  ax_t      aw_q, aw_d;
  w_t       w_q, w_d;
  logic     wsel_q, wsel_d;
  // Set while the channel holds a beat not yet handed to the slave.
  logic     aw_hold_q, aw_hold_d;
  logic     w_hold_q, w_hold_d;
  logic     awready_int, wready_int, aw_fwd, w_fwd, b_pass;

  logic     awready_sel, wready_sel, bvalid_sel;

  assign awready_sel = wsel_q ? s1_axi.awready : s0_axi.awready;
  assign wready_sel  = wsel_q ? s1_axi.wready  : s0_axi.wready;
  assign bvalid_sel  = wsel_q ? s1_axi.bvalid  : s0_axi.bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      w_q       <= '0;
      wsel_q    <= 1'b0;
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      wsel_q    <= wsel_d;
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
    end
  end

  always_comb begin
    w_state_d   = w_state_q;
    aw_d        = aw_q;
    w_d         = w_q;
    wsel_d      = wsel_q;
    aw_hold_d   = aw_hold_q;
    w_hold_d    = w_hold_q;
    awready_int = 1'b0;
    wready_int  = 1'b0;
    aw_fwd      = 1'b0;
    w_fwd       = 1'b0;
    b_pass      = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        // AW and W are collected independently, in either order or together.
        awready_int = !aw_hold_q;
        wready_int  = !w_hold_q;
        if (m_axi.awvalid && !aw_hold_q) begin
          aw_d.addr  = m_axi.awaddr;
          aw_d.id    = m_axi.awid;
          aw_d.len   = m_axi.awlen;
          aw_d.size  = m_axi.awsize;
          aw_d.burst = m_axi.awburst;
          wsel_d     = is_clint(m_axi.awaddr);
          aw_hold_d  = 1'b1;
        end
        if (m_axi.wvalid && !w_hold_q) begin
          w_d.data = m_axi.wdata;
          w_d.strb = m_axi.wstrb;
          w_d.last = m_axi.wlast;
          w_hold_d = 1'b1;
        end
        if (aw_hold_d && w_hold_d) w_state_d = W_REQ;
      end
      W_REQ: begin
        aw_fwd = aw_hold_q;
        w_fwd  = w_hold_q;
        if (aw_hold_q && awready_sel) aw_hold_d = 1'b0;
        if (w_hold_q && wready_sel)   w_hold_d  = 1'b0;
        if (!aw_hold_d && !w_hold_d)  w_state_d = W_RESP;
      end
      W_RESP: begin
        b_pass = 1'b1;
        if (bvalid_sel && m_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign m_axi.awready  = awready_int;
  assign m_axi.wready   = wready_int;

  assign s0_axi.awvalid = aw_fwd && !wsel_q;
  assign s1_axi.awvalid = aw_fwd &&  wsel_q;
  assign s0_axi.awaddr  = aw_q.addr;
  assign s1_axi.awaddr  = aw_q.addr;
  assign s0_axi.awid    = aw_q.id;
  assign s1_axi.awid    = aw_q.id;
  assign s0_axi.awlen   = aw_q.len;
  assign s1_axi.awlen   = aw_q.len;
  assign s0_axi.awsize  = aw_q.size;
  assign s1_axi.awsize  = aw_q.size;
  assign s0_axi.awburst = aw_q.burst;
  assign s1_axi.awburst = aw_q.burst;

  assign s0_axi.wvalid  = w_fwd && !wsel_q;
  assign s1_axi.wvalid  = w_fwd &&  wsel_q;
  assign s0_axi.wdata   = w_q.data;
  assign s1_axi.wdata   = w_q.data;
  assign s0_axi.wstrb   = w_q.strb;
  assign s1_axi.wstrb   = w_q.strb;
  assign s0_axi.wlast   = w_q.last;
  assign s1_axi.wlast   = w_q.last;

  assign m_axi.bvalid   = b_pass && bvalid_sel;
  assign m_axi.bresp    = wsel_q ? s1_axi.bresp : s0_axi.bresp;
  assign m_axi.bid      = wsel_q ? s1_axi.bid   : s0_axi.bid;
  assign s0_axi.bready  = b_pass && !wsel_q && m_axi.bready;
  assign s1_axi.bready  = b_pass &&  wsel_q && m_axi.bready;

endmodule
